// File: rtl/hdlverifier_jtag_dr_shifter.sv
// JTAG user DR engine in the tck domain: capture/shift/update into an addressed channel register file.
// Latency: write lands and ch_wr_pulse fires one tck after UPDATE-DR; no backpressure (the host owns the scan clock).
module hdlverifier_jtag_dr_shifter #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter int                NUM_CH  = 4,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                       tck,
    input  logic                       jtag_reset_n,
    input  logic                       tdi,
    output logic                       tdo,
    input  logic                       capture_dr,
    input  logic                       shift_dr,
    input  logic                       update_dr,
    output logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_wr_pulse,
    input  logic [NUM_CH*DATA_W-1:0]   ch_rdata,
    output logic                       len_err
);

    localparam int DR_LEN = DATA_W + ADDR_W + 1;
    localparam int CNT_W  = $clog2(DR_LEN + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DR_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DR_LEN + 1);
    localparam logic [ADDR_W:0]   NUM_CH_X = (ADDR_W + 1)'(NUM_CH);

    logic [DR_LEN-1:0] sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdsel;

    logic [DATA_W-1:0] fr_data;
    logic [ADDR_W-1:0] fr_addr;
    logic              fr_wr;
    logic              frame_ok;
    logic              addr_ok;
    logic              do_update;
    logic              wr_hit;

    assign fr_data   = sr[DATA_W-1:0];
    assign fr_addr   = sr[DATA_W +: ADDR_W];
    assign fr_wr     = sr[DR_LEN-1];
    assign frame_ok  = (bit_cnt == CNT_FULL);
    assign addr_ok   = ({1'b0, fr_addr} < NUM_CH_X);
    // Capture and shift outrank update so an overlapping strobe cannot commit a frame.
    assign do_update = update_dr & ~capture_dr & ~shift_dr;
    assign wr_hit    = do_update & frame_ok & fr_wr & addr_ok;

    assign tdo = sr[0];

    always_comb begin
        rdsel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rdsel = ch_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge tck or negedge jtag_reset_n) begin
        if (!jtag_reset_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            rd_addr <= '0;
            len_err <= 1'b0;
        end else if (capture_dr) begin
            sr      <= {len_err, rd_addr, rdsel};
            bit_cnt <= '0;
        end else if (shift_dr) begin
            sr <= {tdi, sr[DR_LEN-1:1]};
            if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (update_dr) begin
            if (frame_ok) begin
                rd_addr <= fr_addr;
                len_err <= 1'b0;
            end else begin
                len_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge tck or negedge jtag_reset_n) begin
        if (!jtag_reset_n) begin
            ch_wdata    <= {NUM_CH{RST_VAL}};
            ch_wr_pulse <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_wr_pulse[k] <= wr_hit && (fr_addr == ADDR_W'(k));
                if (wr_hit && (fr_addr == ADDR_W'(k))) begin
                    ch_wdata[k*DATA_W +: DATA_W] <= fr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdlverifier_jtag_dr_shifter.sv
// Directed bench for the JTAG DR shifter with a frame-level reference model checked every tck.
module tb_hdlverifier_jtag_dr_shifter;

    localparam int DR_LEN = 13;

    logic        tck = 1'b0;
    logic        jtag_reset_n = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic [31:0] ch_wdata;
    logic [3:0]  ch_wr_pulse;
    logic [31:0] ch_rdata = '0;
    logic        len_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    hdlverifier_jtag_dr_shifter #(
        .DATA_W(8), .ADDR_W(4), .NUM_CH(4), .RST_VAL(8'h00)
    ) dut (
        .tck(tck), .jtag_reset_n(jtag_reset_n), .tdi(tdi), .tdo(tdo),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .ch_wdata(ch_wdata), .ch_wr_pulse(ch_wr_pulse), .ch_rdata(ch_rdata),
        .len_err(len_err)
    );

    always #5 tck = ~tck;

    // Reference model: the scan chain as a bit queue, frame decoded only at update.
    logic       q[$];
    logic [7:0] m_ch[4] = '{default: 8'h00};
    logic [3:0] m_rd = '0;
    logic       m_err = 1'b0;
    logic [3:0] m_pulse = '0;
    int         m_cnt = 0;

    initial for (int i = 0; i < DR_LEN; i++) q.push_back(1'b0);

    always @(posedge tck or negedge jtag_reset_n) begin
        if (!jtag_reset_n) begin
            m_ch    = '{default: 8'h00};
            m_rd    = '0;
            m_err   = 1'b0;
            m_pulse = '0;
            m_cnt   = 0;
            q       = {};
            for (int i = 0; i < DR_LEN; i++) q.push_back(1'b0);
        end else begin
            m_pulse = '0;
            if (capture_dr) begin
                logic [7:0]  rd;
                logic [12:0] w;
                rd = (m_rd < 4) ? ch_rdata[m_rd*8 +: 8] : 8'h00;
                w  = {m_err, m_rd, rd};
                q  = {};
                for (int i = 0; i < DR_LEN; i++) q.push_back(w[i]);
                m_cnt = 0;
            end else if (shift_dr) begin
                void'(q.pop_front());
                q.push_back(tdi);
                m_cnt++;
            end else if (update_dr) begin
                if (m_cnt == DR_LEN) begin
                    logic [7:0] d;
                    logic [3:0] a;
                    for (int i = 0; i < 8; i++) d[i] = q[i];
                    for (int i = 0; i < 4; i++) a[i] = q[8+i];
                    m_rd  = a;
                    m_err = 1'b0;
                    if (q[12] && a < 4) begin
                        m_ch[a]    = d;
                        m_pulse[a] = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge tck) begin
        if (chk_en) begin
            chk("model_tdo", {31'd0, tdo}, {31'd0, q[0]});
            chk("model_wdata", ch_wdata, {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
            chk("model_pulse", {28'd0, ch_wr_pulse}, {28'd0, m_pulse});
            chk("model_len_err", {31'd0, len_err}, {31'd0, m_err});
        end
    end

    // Capture, shift nshift bits of {wr,addr,data} LSB first, update; got holds tdo seen per shift.
    task automatic frame(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                         input int nshift, output logic [12:0] got);
        logic [12:0] w;
        w   = {wr, addr, data};
        got = '0;
        @(negedge tck); capture_dr = 1'b1;
        @(negedge tck); capture_dr = 1'b0;
        for (int i = 0; i < nshift; i++) begin
            shift_dr = 1'b1;
            tdi      = (i < DR_LEN) ? w[i] : 1'b0;
            if (i < DR_LEN) got[i] = tdo;
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
    endtask

    logic [12:0] got;

    initial begin
        repeat (2) @(negedge tck);
        chk_en = 1'b1;
        // T1 reset state
        chk("rst_tdo", {31'd0, tdo}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        chk("rst_pulse", {28'd0, ch_wr_pulse}, 32'd0);
        chk("rst_wdata", ch_wdata, 32'd0);
        #2 jtag_reset_n = 1'b1;

        // T2 write ch2 = A5
        frame(1'b1, 4'd2, 8'hA5, DR_LEN, got);
        chk("t2_wdata", ch_wdata, 32'h00A5_0000);
        chk("t2_pulse", {28'd0, ch_wr_pulse}, 32'h4);
        @(negedge tck);
        chk("t2_pulse_gone", {28'd0, ch_wr_pulse}, 32'h0);

        // T3 select ch1, then read it back
        ch_rdata[15:8] = 8'h3C;
        frame(1'b0, 4'd1, 8'h00, DR_LEN, got);
        chk("t3_no_pulse", {28'd0, ch_wr_pulse}, 32'h0);
        frame(1'b0, 4'd1, 8'h00, DR_LEN, got);
        chk("t3_read_word", {19'd0, got}, 32'h013C);

        // T4 short frame
        frame(1'b1, 4'd0, 8'h55, DR_LEN - 1, got);
        chk("t4_no_write", ch_wdata, 32'h00A5_0000);
        chk("t4_len_err", {31'd0, len_err}, 32'd1);
        frame(1'b0, 4'd1, 8'h00, DR_LEN, got);
        chk("t4_err_bit_out", {31'd0, got[12]}, 32'd1);
        chk("t4_rd_kept", {24'd0, got[7:0]}, 32'h3C);
        chk("t4_err_cleared", {31'd0, len_err}, 32'd0);

        // Long frame also flags a length error
        frame(1'b1, 4'd3, 8'h77, DR_LEN + 3, got);
        chk("long_len_err", {31'd0, len_err}, 32'd1);
        chk("long_no_write", ch_wdata, 32'h00A5_0000);

        // T5 out-of-range write
        frame(1'b1, 4'd7, 8'hFF, DR_LEN, got);
        chk("t5_no_pulse", {28'd0, ch_wr_pulse}, 32'h0);
        chk("t5_wdata", ch_wdata, 32'h00A5_0000);
        chk("t5_no_err", {31'd0, len_err}, 32'd0);
        frame(1'b0, 4'd7, 8'h00, DR_LEN, got);
        chk("t5_read_data", {24'd0, got[7:0]}, 32'h00);
        chk("t5_read_addr", {28'd0, got[11:8]}, 32'h7);

        // All strobes at once: capture wins, nothing is written
        @(negedge tck); capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
        @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        chk("prio_no_pulse", {28'd0, ch_wr_pulse}, 32'h0);
        @(negedge tck);

        // T6 reset after six shifts
        @(negedge tck); capture_dr = 1'b1;
        @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b1; tdi = 1'b1;
        repeat (6) @(negedge tck);
        shift_dr = 1'b0;
        #2 jtag_reset_n = 1'b0;
        @(negedge tck);
        chk("t6_tdo", {31'd0, tdo}, 32'd0);
        chk("t6_wdata", ch_wdata, 32'd0);
        chk("t6_len_err", {31'd0, len_err}, 32'd0);
        chk("t6_pulse", {28'd0, ch_wr_pulse}, 32'd0);
        #2 jtag_reset_n = 1'b1;
        frame(1'b1, 4'd0, 8'h11, DR_LEN, got);
        chk("t6_write_ch0", ch_wdata, 32'h0000_0011);
        chk("t6_pulse_ch0", {28'd0, ch_wr_pulse}, 32'h1);
        repeat (2) @(negedge tck);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
